dispatch_unit: RTL

DISPATCH_UNIT -- requirements
Module: dispatch_unit

---
 rtl/dispatch_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dispatch_unit.sv
// rtl/dispatch_unit.sv - register rename/dispatch stage feeding the reservation station; DISPATCH_STATS_EN adds counters
module dispatch_unit #(
    parameter int Q_WIDTH = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               control_hazard,
    input  logic               inst_valid,
    output logic               inst_ready,
    input  logic [9:0]         inst_op,
    input  logic [4:0]         inst_rd,
    input  logic [4:0]         inst_rs1,
    input  logic [4:0]         inst_rs2,
    input  logic [31:0]        inst_imm,
    input  logic [31:0]        inst_npc,
    input  logic [Q_WIDTH-1:0] rob_tag_alloc,
    input  logic               rob_full,
    output logic               rob_alloc,
    input  logic               RS_Full,
    input  logic               update_control,
    input  logic [Q_WIDTH-1:0] target_ROB_pos,
    input  logic [31:0]        V_ex,
    input  logic               has_slb_result,
    input  logic [Q_WIDTH-1:0] slb_target_ROB_pos,
    input  logic [31:0]        V_slb,
    input  logic               commit_valid,
    input  logic [4:0]         commit_rd,
    input  logic [Q_WIDTH-1:0] commit_tag,
    input  logic [31:0]        commit_value,
    output logic               input_valid,
    output logic [Q_WIDTH-1:0] rob_tag_input,
    output logic [9:0]         op_input,
    output logic [Q_WIDTH-1:0] Q1_input,
    output logic [Q_WIDTH-1:0] Q2_input,
    output logic [31:0]        V1_input,
    output logic [31:0]        V2_input,
    output logic [31:0]        immediate_input,
    output logic [31:0]        npc_input
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]        dispatch_count,
    output logic [31:0]        stall_count
`endif
);

    logic [31:0]        regval [32];
    logic [Q_WIDTH-1:0] qtag   [32];

    logic               can_issue;
    logic               fire;
    logic [Q_WIDTH-1:0] q1_next;
    logic [Q_WIDTH-1:0] q2_next;
    logic [31:0]        v1_next;
    logic [31:0]        v2_next;

    // input_valid blocks issue because RS_Full does not yet reflect the pending entry
    always_comb begin
        can_issue = !rst_in && rdy_in && !rob_full && !RS_Full && !control_hazard && !input_valid;
        fire      = can_issue && inst_valid;
    end

    assign inst_ready = can_issue;
    assign rob_alloc  = fire;

    // Returns {Q, V}; qt is the tag table entry before any same-cycle rename.
    function automatic logic [Q_WIDTH+31:0] resolve(
        input logic [4:0]         rs,
        input logic [Q_WIDTH-1:0] qt,
        input logic [31:0]        rv
    );
        if (rs == 5'd0)
            return '0;
        else if (qt == '0)
            return {{Q_WIDTH{1'b0}}, rv};
        else if (update_control && target_ROB_pos == qt)
            return {{Q_WIDTH{1'b0}}, V_ex};
        else if (has_slb_result && slb_target_ROB_pos == qt)
            return {{Q_WIDTH{1'b0}}, V_slb};
        else if (commit_valid && commit_tag == qt)
            return {{Q_WIDTH{1'b0}}, commit_value};
        else
            return {qt, 32'd0};
    endfunction

    always_comb begin
        {q1_next, v1_next} = resolve(inst_rs1, qtag[inst_rs1], regval[inst_rs1]);
        {q2_next, v2_next} = resolve(inst_rs2, qtag[inst_rs2], regval[inst_rs2]);
    end

    // Later assignments win: a same-cycle rename overrides the commit's tag clear
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
                regval[i] <= '0;
                qtag[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (commit_valid && commit_rd != 5'd0) begin
                regval[commit_rd] <= commit_value;
                if (qtag[commit_rd] == commit_tag)
                    qtag[commit_rd] <= '0;
            end
            if (control_hazard) begin
                for (int i = 0; i < 32; i++)
                    qtag[i] <= '0;
            end else if (fire && inst_rd != 5'd0) begin
                qtag[inst_rd] <= rob_tag_alloc;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            input_valid     <= 1'b0;
            rob_tag_input   <= '0;
            op_input        <= '0;
            Q1_input        <= '0;
            Q2_input        <= '0;
            V1_input        <= '0;
            V2_input        <= '0;
            immediate_input <= '0;
            npc_input       <= '0;
        end else if (rdy_in) begin
            if (fire) begin
                input_valid     <= 1'b1;
                rob_tag_input   <= rob_tag_alloc;
                op_input        <= inst_op;
                Q1_input        <= q1_next;
                Q2_input        <= q2_next;
                V1_input        <= v1_next;
                V2_input        <= v2_next;
                immediate_input <= inst_imm;
                npc_input       <= inst_npc;
            end else begin
                input_valid <= 1'b0;
            end
        end
    end

`ifdef DISPATCH_STATS_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dispatch_count <= '0;
            stall_count    <= '0;
        end else begin
            if (fire)
                dispatch_count <= dispatch_count + 32'd1;
            if (inst_valid && rdy_in && !fire)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule
